// File: rtl/as6d_pcs_rx_deinterleaver_ctrl.sv
// PCS RX deinterleaver controller: row-major ping-pong writes into a 128x72 ECC RAM,
// column-major reads through a skid FIFO with ready/valid output and ECC statistics.
//
// state          | meaning
// BANK_EMPTY     | bank free, waiting for an in_sof word
// BANK_FILLING   | block being written row-major
// BANK_FULL      | all words written, no read issued yet
// BANK_DRAINING  | column-major reads in progress
module as6d_pcs_rx_deinterleaver_ctrl #(
  parameter int DATA_WIDTH = 72,
  parameter int ROW_BITS   = 3,
  parameter int COL_BITS   = 3,
  parameter int ADDR_WIDTH = 7,
  parameter int RD_LAT     = 2,
  parameter int SKID_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  out_sbe,
  output logic                  out_dbe,
  output logic [ADDR_WIDTH-1:0] ram_aa,
  output logic                  ram_csa,
  output logic                  ram_wea,
  output logic [DATA_WIDTH-1:0] ram_da,
  output logic                  ram_csb,
  output logic                  ram_reb,
  output logic [ADDR_WIDTH-1:0] ram_ab,
  input  logic [DATA_WIDTH-1:0] ram_qb,
  input  logic                  ram_single_err,
  input  logic                  ram_double_err,
  output logic [CNT_WIDTH-1:0]  stat_sbe_cnt,
  output logic [CNT_WIDTH-1:0]  stat_dbe_cnt,
  output logic [CNT_WIDTH-1:0]  stat_sof_err
);

  localparam int IDX_BITS = ROW_BITS + COL_BITS;
  localparam int PTR_BITS = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OCC_BITS = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sbe;
    logic                  dbe;
    logic                  sof;
    logic                  eof;
  } skid_entry_t;

  bank_state_e           bank_q [2];
  bank_state_e           bank_d [2];
  logic                  wr_bank_q, rd_bank_q;
  logic [IDX_BITS-1:0]   wr_cnt_q, rd_cnt_q;
  logic [RD_LAT-1:0]     vld_sr_q;
  logic [1:0]            tag_sr_q [RD_LAT];
  skid_entry_t           fifo_q [SKID_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OCC_BITS-1:0]   occ_q, inflight;
  logic [OCC_BITS:0]     outstanding;

  bank_state_e           wr_st, rd_st;
  logic                  accept, wr_en, wr_last, sof_restart;
  logic [IDX_BITS-1:0]   wr_idx;
  logic                  rd_avail, rd_issue, rd_last;
  logic [1:0]            rd_tag;
  logic                  push, pop;
  skid_entry_t           head;

  // ---------------- write side ----------------
  assign wr_st       = bank_q[wr_bank_q];
  assign in_ready    = cfg_en & ((wr_st == BANK_EMPTY) | (wr_st == BANK_FILLING));
  assign accept      = in_valid & in_ready;
  // non-sof words arriving into an empty bank are silently dropped
  assign wr_en       = accept & (in_sof | (wr_st == BANK_FILLING));
  assign wr_idx      = in_sof ? '0 : wr_cnt_q;
  assign wr_last     = wr_en & (&wr_idx);
  assign sof_restart = accept & in_sof & (wr_st == BANK_FILLING);

  assign ram_csa = wr_en;
  assign ram_wea = wr_en;
  assign ram_aa  = wr_en ? {wr_bank_q, wr_idx} : '0;
  assign ram_da  = wr_en ? in_data : '0;

  // ---------------- read side ----------------
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCC_BITS'(vld_sr_q[i]);
  end

  // reads are only issued when the FIFO is guaranteed to have room on return
  assign outstanding = {1'b0, inflight} + {1'b0, occ_q};
  assign rd_st       = bank_q[rd_bank_q];
  assign rd_avail    = (rd_st == BANK_FULL) | (rd_st == BANK_DRAINING);
  assign rd_issue    = cfg_en & rd_avail & (outstanding < (OCC_BITS+1)'(SKID_DEPTH));
  assign rd_last     = rd_issue & (&rd_cnt_q);
  assign rd_tag      = {(rd_cnt_q == '0), (&rd_cnt_q)};

  assign ram_csb = rd_issue;
  assign ram_reb = rd_issue;
  assign ram_ab  = rd_issue ? {rd_bank_q, rd_cnt_q[ROW_BITS-1:0], rd_cnt_q[IDX_BITS-1:ROW_BITS]} : '0;

  // ---------------- bank FSMs ----------------
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b];
      if (wr_en && (wr_bank_q == 1'(b))) bank_d[b] = wr_last ? BANK_FULL : BANK_FILLING;
      if (rd_issue && (rd_bank_q == 1'(b))) bank_d[b] = rd_last ? BANK_EMPTY : BANK_DRAINING;
      if (!cfg_en) bank_d[b] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else if (!cfg_en) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      if (wr_en) wr_cnt_q <= wr_last ? '0 : wr_idx + 1'b1;
      if (wr_last) wr_bank_q <= ~wr_bank_q;
      if (rd_issue) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (rd_last) rd_bank_q <= ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_sr_q[i] <= 2'b00;
    end else begin
      vld_sr_q[0] <= rd_issue;
      tag_sr_q[0] <= rd_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1] & cfg_en;
        tag_sr_q[i] <= tag_sr_q[i-1];
      end
    end
  end

  // ---------------- skid FIFO ----------------
  assign push      = cfg_en & vld_sr_q[RD_LAT-1];
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid & out_ready;
  assign head      = fifo_q[rd_ptr_q];
  assign out_data  = out_valid ? head.data : '0;
  assign out_sbe   = out_valid & head.sbe;
  assign out_dbe   = out_valid & head.dbe;
  assign out_sof   = out_valid & head.sof;
  assign out_eof   = out_valid & head.eof;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {ram_qb, ram_single_err, ram_double_err, tag_sr_q[RD_LAT-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (!cfg_en) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_BITS'(SKID_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_BITS'(SKID_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      occ_q <= occ_q + OCC_BITS'(push) - OCC_BITS'(pop);
    end
  end

  // ---------------- statistics ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sbe_cnt <= '0;
      stat_dbe_cnt <= '0;
      stat_sof_err <= '0;
    end else begin
      if (pop && out_sbe && (stat_sbe_cnt != '1)) stat_sbe_cnt <= stat_sbe_cnt + 1'b1;
      if (pop && out_dbe && (stat_dbe_cnt != '1)) stat_dbe_cnt <= stat_dbe_cnt + 1'b1;
      if (sof_restart && (stat_sof_err != '1)) stat_sof_err <= stat_sof_err + 1'b1;
    end
  end

  // write and read banks are always distinct, so the RAM never sees a same-address collision
  a_no_collision: assert property (@(posedge clk) disable iff (!rst_n)
    (ram_csa && ram_csb) |-> (ram_aa[ADDR_WIDTH-1] != ram_ab[ADDR_WIDTH-1]));

endmodule
